// File: rtl/vga_multi_cursor_pkg.sv
// Purpose: shared cursor register layout, mode encodings and blink phase constant.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package vga_multi_cursor_pkg;

    // Cursor register field positions
    localparam int IDX_LSB   = 0;
    localparam int IDX_W     = 11;
    localparam int COLOR_LSB = 16;
    localparam int COLOR_W   = 6;
    localparam int MODE_LSB  = 24;
    localparam int MODE_W    = 2;
    localparam int BLINK_BIT = 26;
    localparam int PHASE_BIT = 31;

    // Bits that are actually stored; everything else reads back as zero
    localparam logic [31:0] REG_MASK = 32'h073F_07FF;

    // Cursor shape modes
    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_UNDER = 2'b01;
    localparam logic [1:0] MODE_BAR   = 2'b10;
    localparam logic [1:0] MODE_BLOCK = 2'b11;

    // Blink phase value meaning "cursor drawn"
    localparam logic PHASE_VISIBLE = 1'b1;

    typedef struct packed {
        logic               blink;
        logic [MODE_W-1:0]  mode;
        logic [COLOR_W-1:0] color;
        logic [IDX_W-1:0]   idx;
    } cursor_t;

    function automatic cursor_t unpack_cursor(input logic [31:0] r);
        cursor_t c;
        c.blink = r[BLINK_BIT];
        c.mode  = r[MODE_LSB +: MODE_W];
        c.color = r[COLOR_LSB +: COLOR_W];
        c.idx   = r[IDX_LSB +: IDX_W];
        return c;
    endfunction

    // RRGGBB (2 bits each) widened to 4-4-4 RGB with the low bits zero
    function automatic logic [11:0] expand_color(input logic [COLOR_W-1:0] c);
        return {c[5:4], 2'b00, c[3:2], 2'b00, c[1:0], 2'b00};
    endfunction

endpackage

// File: rtl/vga_multi_cursor_blink.sv
// Purpose: free-running blink half-period counter and visibility phase.
// Latency: phase toggles on the edge where the counter wraps from BLINK_DIV-1.
// Backpressure: none; never stalls, unaffected by register traffic.
module cursor_blink
    import vga_multi_cursor_pkg::*;
#(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    output logic phase
);

    localparam int CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0] cnt;

    // Count 0..BLINK_DIV-1, toggle phase on each wrap; reset restarts a visible half-period
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            phase <= PHASE_VISIBLE;
        end else if (cnt == CNT_W'(BLINK_DIV - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_multi_cursor.sv
// Purpose: up to 8 text-mode hardware cursors with byte-writable registers and priority overlay.
// Latency: 1 cycle pixel path; read data registered, valid 1 cycle after rd.
// Backpressure: none; accepts a register access and a pixel every cycle.
module vga_multi_cursor
    import vga_multi_cursor_pkg::*;
#(
    parameter int N_CUR     = 4,
    parameter int COLS      = 40,
    parameter int CELL_LOG2 = 4,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  we,
    input  logic        rd,
    input  logic [2:0]  reg_addr,
    input  logic [31:0] data_in,
    input  logic [9:0]  vga_column,
    input  logic [8:0]  vga_row,
    output logic [31:0] data_out,
    output logic [11:0] color_out,
    output logic        cursor_on,
    output logic [2:0]  hit_id
);

    logic [31:0]          cur_regs [N_CUR];
    logic                 phase;
    logic                 addr_ok;
    logic [31:0]          sel_reg;
    logic [31:0]          wr_merged;
    logic [31:0]          rd_word;
    logic [10:0]          cell_addr;
    logic [CELL_LOG2-1:0] col_off;
    logic [CELL_LOG2-1:0] row_off;
    cursor_t              cur_c;
    logic                 shape_hit;
    logic                 on_nxt;
    logic [2:0]           id_nxt;
    logic [11:0]          color_nxt;

    cursor_blink #(.BLINK_DIV(BLINK_DIV)) u_blink (
        .clk   (clk),
        .rst   (rst),
        .phase (phase)
    );

    assign addr_ok = (32'(reg_addr) < 32'(N_CUR));

    // Select the addressed register (zero when out of range)
    always_comb begin
        sel_reg = '0;
        for (int i = 0; i < N_CUR; i++) begin
            if (reg_addr == 3'(i)) sel_reg = cur_regs[i];
        end
    end

    // Byte-lane merge of write data into the addressed register, unused bits forced to 0
    always_comb begin
        wr_merged = sel_reg;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) wr_merged[8*b +: 8] = data_in[8*b +: 8];
        end
        wr_merged = wr_merged & REG_MASK;
    end

    // Read word carries the live blink phase in its top bit
    always_comb begin
        rd_word            = sel_reg;
        rd_word[PHASE_BIT] = phase;
    end

    // Cursor register file; out-of-range addresses never alias onto a real cursor
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CUR; i++) cur_regs[i] <= '0;
        end else if (addr_ok && (we != 4'b0000)) begin
            for (int i = 0; i < N_CUR; i++) begin
                if (reg_addr == 3'(i)) cur_regs[i] <= wr_merged;
            end
        end
    end

    // Registered read port; reads the pre-write value on a same-cycle write
    always_ff @(posedge clk) begin
        if (rst)                data_out <= '0;
        else if (rd && addr_ok) data_out <= rd_word;
        else                    data_out <= '0;
    end

    // Character cell of the current pixel and the offset inside it
    assign cell_addr = 11'(32'(vga_row >> CELL_LOG2) * 32'(COLS) + 32'(vga_column >> CELL_LOG2));
    assign col_off   = vga_column[CELL_LOG2-1:0];
    assign row_off   = vga_row[CELL_LOG2-1:0];

    // Priority match: scan high to low so the lowest matching index has the final say
    always_comb begin
        on_nxt    = 1'b0;
        id_nxt    = '0;
        color_nxt = '0;
        cur_c     = '0;
        shape_hit = 1'b0;
        for (int i = N_CUR - 1; i >= 0; i--) begin
            cur_c = unpack_cursor(cur_regs[i]);
            if ((cur_c.mode != MODE_OFF) && (cur_c.idx == cell_addr)) begin
                case (cur_c.mode)
                    MODE_BLOCK: shape_hit = 1'b1;
                    MODE_BAR:   shape_hit = (col_off == '0);
                    MODE_UNDER: shape_hit = (row_off == '1);
                    default:    shape_hit = 1'b0;
                endcase
                on_nxt    = 1'b1;
                id_nxt    = 3'(i);
                color_nxt = (shape_hit && (!cur_c.blink || (phase == PHASE_VISIBLE)))
                            ? expand_color(cur_c.color) : 12'h000;
            end
        end
    end

    // One-cycle pixel output register
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_on <= 1'b0;
            hit_id    <= '0;
            color_out <= '0;
        end else begin
            cursor_on <= on_nxt;
            hit_id    <= id_nxt;
            color_out <= color_nxt;
        end
    end

endmodule

// File: tb/tb_vga_multi_cursor.sv
// Purpose: directed self-checking bench for vga_multi_cursor.
// Latency: expects 1-cycle pixel and read latency.
// Backpressure: n/a.
module tb_vga_multi_cursor;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  we;
    logic        rd;
    logic [2:0]  reg_addr;
    logic [31:0] data_in;
    logic [9:0]  vga_column;
    logic [8:0]  vga_row;
    logic [31:0] data_out;
    logic [11:0] color_out;
    logic        cursor_on;
    logic [2:0]  hit_id;

    int checks = 0;
    int errors = 0;
    int ecount = 0;   // clock edges seen since reset was last sampled high

    always #5 clk = ~clk;

    always @(posedge clk) ecount <= rst ? 0 : ecount + 1;

    vga_multi_cursor #(
        .N_CUR(4), .COLS(40), .CELL_LOG2(4), .BLINK_DIV(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .rd         (rd),
        .reg_addr   (reg_addr),
        .data_in    (data_in),
        .vga_column (vga_column),
        .vga_row    (vga_row),
        .data_out   (data_out),
        .color_out  (color_out),
        .cursor_on  (cursor_on),
        .hit_id     (hit_id)
    );

    // Phase seen by registered outputs after edge k: phase after k-1 free edges,
    // starting at 1 and toggling every 4 edges.
    function automatic logic exp_phase(input int k);
        if (k <= 1) return 1'b1;
        return ((((k - 1) / 4) % 2) == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [3:0] w, input logic [31:0] d);
        reg_addr = a;
        we       = w;
        data_in  = d;
        tick();
        we = 4'b0000;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] v, output logic ph);
        reg_addr = a;
        rd       = 1'b1;
        tick();
        rd = 1'b0;
        v  = data_out;
        ph = exp_phase(ecount);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic        ph;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({data_out, cursor_on, hit_id, color_out} !== 48'h0) begin
            errors++;
            $display("FAIL reset_outputs: got dout=%h on=%b id=%0d col=%h, expected all zero",
                     data_out, cursor_on, hit_id, color_out);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_read(3'(i), v, ph);
            checks++;
            if (v !== {ph, 31'h0}) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h", i, v, {ph, 31'h0});
            end
        end
    endtask

    task automatic test_block();
        logic [15:0] exp_v;
        do_write(3'd0, 4'b1111, 32'h032A_0005);
        vga_row = 9'd0;
        for (int c = 64; c < 112; c++) begin
            vga_column = 10'(c);
            tick();
            exp_v = (c >= 80 && c <= 95) ? {1'b1, 3'd0, 12'h888} : 16'h0;
            checks++;
            if ({cursor_on, hit_id, color_out} !== exp_v) begin
                errors++;
                $display("FAIL block_col%0d: got on=%b id=%0d col=%h expected %h",
                         c, cursor_on, hit_id, color_out, exp_v);
            end
        end
    endtask

    task automatic test_priority();
        logic [15:0] exp_v;
        do_write(3'd1, 4'b1111, 32'h023F_0005);
        do_write(3'd0, 4'b1111, 32'h0130_0005);
        for (int r = 0; r < 16; r++) begin
            for (int c = 80; c < 96; c++) begin
                vga_row    = 9'(r);
                vga_column = 10'(c);
                tick();
                exp_v = {1'b1, 3'd0, (r == 15) ? 12'hC00 : 12'h000};
                checks++;
                if ({cursor_on, hit_id, color_out} !== exp_v) begin
                    errors++;
                    $display("FAIL prio_r%0d_c%0d: got on=%b id=%0d col=%h expected %h",
                             r, c, cursor_on, hit_id, color_out, exp_v);
                end
            end
        end
        // Row 16 lands in cell 45: no cursor there
        vga_row = 9'd16; vga_column = 10'd80;
        tick();
        checks++;
        if ({cursor_on, hit_id, color_out} !== 16'h0) begin
            errors++;
            $display("FAIL prio_cell45: got on=%b id=%0d col=%h expected 0", cursor_on, hit_id, color_out);
        end
        // Turn cursor 0 off while holding a pixel: change shows one edge after the write
        vga_row = 9'd3; vga_column = 10'd80;
        tick();
        do_write(3'd0, 4'b1000, 32'h0000_0000);
        checks++;
        if ({cursor_on, hit_id, color_out} !== {1'b1, 3'd0, 12'h000}) begin
            errors++;
            $display("FAIL write_latency_old: got on=%b id=%0d col=%h expected on=1 id=0 col=000",
                     cursor_on, hit_id, color_out);
        end
        tick();
        checks++;
        if ({cursor_on, hit_id, color_out} !== {1'b1, 3'd1, 12'hCCC}) begin
            errors++;
            $display("FAIL write_latency_new: got on=%b id=%0d col=%h expected on=1 id=1 col=ccc",
                     cursor_on, hit_id, color_out);
        end
        vga_column = 10'd81;
        tick();
        checks++;
        if ({cursor_on, hit_id, color_out} !== {1'b1, 3'd1, 12'h000}) begin
            errors++;
            $display("FAIL bar_off_col: got on=%b id=%0d col=%h expected on=1 id=1 col=000",
                     cursor_on, hit_id, color_out);
        end
    endtask

    task automatic test_bytes();
        logic [31:0] v;
        logic        ph;
        do_write(3'd2, 4'b0100, 32'hFFFF_FFFF);
        do_read(3'd2, v, ph);
        checks++;
        if (v !== {ph, 31'h003F_0000}) begin
            errors++;
            $display("FAIL byte2_write: got %h expected %h", v, {ph, 31'h003F_0000});
        end
        do_read(3'd6, v, ph);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL read_addr6: got %h expected 00000000", v);
        end
        do_write(3'd3, 4'b1111, 32'hFFFF_FFFF);
        do_read(3'd3, v, ph);
        checks++;
        if (v !== {ph, 31'h073F_07FF}) begin
            errors++;
            $display("FAIL mask_all_ones: got %h expected %h", v, {ph, 31'h073F_07FF});
        end
        // Out-of-range write must not alias onto cursor 0
        do_write(3'd4, 4'b1111, 32'h0300_0009);
        do_read(3'd0, v, ph);
        checks++;
        if (v !== {ph, 31'h0030_0005}) begin
            errors++;
            $display("FAIL oob_write_alias: got %h expected %h", v, {ph, 31'h0030_0005});
        end
        // Simultaneous read and write returns the old value
        reg_addr = 3'd2; rd = 1'b1; we = 4'b1111; data_in = 32'h0000_0123;
        tick();
        rd = 1'b0; we = 4'b0000;
        ph = exp_phase(ecount);
        checks++;
        if (data_out !== {ph, 31'h003F_0000}) begin
            errors++;
            $display("FAIL rw_same_old: got %h expected %h", data_out, {ph, 31'h003F_0000});
        end
        do_read(3'd2, v, ph);
        checks++;
        if (v !== {ph, 31'h0000_0123}) begin
            errors++;
            $display("FAIL rw_same_new: got %h expected %h", v, {ph, 31'h0000_0123});
        end
        tick();
        checks++;
        if (data_out !== 32'h0) begin
            errors++;
            $display("FAIL rd_low_zero: got %h expected 00000000", data_out);
        end
    endtask

    task automatic blink_run(input string tag, input int n, input int wr_at);
        logic [15:0] exp_v;
        for (int i = 0; i < n; i++) begin
            if (i == wr_at) begin
                reg_addr = 3'd0; we = 4'b1111; data_in = 32'h072A_0005;
            end else begin
                we = 4'b0000;
            end
            tick();
            exp_v = {1'b1, 3'd0, exp_phase(ecount) ? 12'h888 : 12'h000};
            checks++;
            if ({cursor_on, hit_id, color_out} !== exp_v) begin
                errors++;
                $display("FAIL %s_%0d: got on=%b id=%0d col=%h expected %h",
                         tag, i, cursor_on, hit_id, color_out, exp_v);
            end
        end
        we = 4'b0000;
    endtask

    task automatic test_blink();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_write(3'd0, 4'b1111, 32'h072A_0005);
        vga_row = 9'd0; vga_column = 10'd85;
        blink_run("blink", 16, 6);
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic        ph;
        tick();
        tick();
        rst = 1'b1; rd = 1'b1; reg_addr = 3'd0; we = 4'b1111; data_in = 32'hFFFF_FFFF;
        tick();
        checks++;
        if ({data_out, cursor_on, hit_id, color_out} !== 48'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got dout=%h on=%b id=%0d col=%h expected all zero",
                     data_out, cursor_on, hit_id, color_out);
        end
        rst = 1'b0; rd = 1'b0; we = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            do_read(3'(i), v, ph);
            checks++;
            if (v !== {ph, 31'h0}) begin
                errors++;
                $display("FAIL reset_mid_reg%0d: got %h expected %h", i, v, {ph, 31'h0});
            end
        end
        do_write(3'd0, 4'b1111, 32'h072A_0005);
        blink_run("blink_restart", 10, -1);
    endtask

    initial begin
        rst = 1'b0; we = 4'b0000; rd = 1'b0; reg_addr = 3'd0; data_in = 32'h0;
        vga_column = 10'd0; vga_row = 9'd0;
        test_reset();
        test_block();
        test_priority();
        test_bytes();
        test_blink();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
